// File: rtl/mine_placer_if.sv
// Handshake and result bundle between a mine_placer and its controller.
// The master drives the request and the random stream. The slave returns status and the mine bitmap.
interface mine_placer_if #(
  parameter int GRID_W = 9,
  parameter int GRID_H = 9
);
  localparam int CELLS     = GRID_W * GRID_H;
  localparam int CELL_BITS = $clog2(CELLS);

  logic                 start;
  logic [CELL_BITS-1:0] safe_cell;
  logic [7:0]           rand_num;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [CELL_BITS-1:0] mine_count;
  logic [CELLS-1:0]     mine_map;

  modport master (
    output start, safe_cell, rand_num,
    input  busy, done, err, mine_count, mine_map
  );

  modport slave (
    input  start, safe_cell, rand_num,
    output busy, done, err, mine_count, mine_map
  );
endinterface

// File: rtl/mine_placer.sv
// Places NUM_MINES distinct mines by rejection-sampling a free-running random stream.
// The latched safe cell is never mined. The bitmap holds until the next accepted start.
module mine_placer #(
  parameter int GRID_W    = 9,
  parameter int GRID_H    = 9,
  parameter int NUM_MINES = 10,
  parameter int MAX_TRIES = 4096
) (
  input logic          clk,
  input logic          rst_n,
  mine_placer_if.slave bus
);
  localparam int CELLS     = GRID_W * GRID_H;
  localparam int CELL_BITS = $clog2(CELLS);
  localparam int TRY_BITS  = $clog2(MAX_TRIES + 1);

  localparam logic [CELL_BITS:0]   CELL_LIMIT = (CELL_BITS+1)'(CELLS);
  localparam logic [CELL_BITS-1:0] LAST_MINE  = CELL_BITS'(NUM_MINES - 1);
  localparam logic [TRY_BITS-1:0]  LAST_TRY   = TRY_BITS'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t               state;
  logic [TRY_BITS-1:0]  tries;
  logic [CELL_BITS-1:0] safe_q;
  logic [CELL_BITS-1:0] count;
  logic [CELLS-1:0]     map;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic [CELL_BITS-1:0] cand;
  logic                 accept;

  // A latched safe cell outside the board never matches an in-range candidate.
  assign cand   = bus.rand_num[CELL_BITS-1:0];
  assign accept = ({1'b0, cand} < CELL_LIMIT) && (cand != safe_q) && !map[cand];

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.mine_count = count;
  assign bus.mine_map   = map;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tries  <= '0;
      safe_q <= '0;
      count  <= '0;
      map    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            map    <= '0;
            count  <= '0;
            err_q  <= 1'b0;
            tries  <= '0;
            safe_q <= bus.safe_cell;
            busy_q <= 1'b1;
            state  <= DRAW;
          end
        end

        DRAW: begin
          tries <= tries + 1'b1;
          if (accept) begin
            map[cand] <= 1'b1;
            count     <= count + 1'b1;
          end
          // Completion wins when the last mine lands on the final allowed try.
          if (accept && count == LAST_MINE) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b0;
            state  <= DONE;
          end else if (tries == LAST_TRY) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: a default instance and a MAX_TRIES=8 instance share one stimulus stream.
// Both instances are compared every cycle against a cell-level behavioural model.
module tb_mine_placer;
  localparam int CELLS     = 81;
  localparam int NUM_MINES = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_d = 1'b0;
  logic [6:0] safe_d = '0;
  logic [7:0] rand_d = 8'd127;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  mine_placer_if bus_a ();
  mine_placer_if bus_b ();

  assign bus_a.start     = start_d;
  assign bus_a.safe_cell = safe_d;
  assign bus_a.rand_num  = rand_d;
  assign bus_b.start     = start_d;
  assign bus_b.safe_cell = safe_d;
  assign bus_b.rand_num  = rand_d;

  mine_placer dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mine_placer #(.MAX_TRIES(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  // Model state per instance: index 0 is the default DUT, index 1 the 8-try DUT.
  bit              m_busy [2] = '{0, 0};
  bit              m_done [2] = '{0, 0};
  bit              m_err  [2] = '{0, 0};
  int              m_count[2] = '{0, 0};
  int              m_tries[2] = '{0, 0};
  int              m_safe [2] = '{0, 0};
  int              m_max  [2] = '{4096, 8};
  logic [CELLS-1:0] m_map [2] = '{'0, '0};

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input int k);
    int cand;
    if (m_done[k]) begin
      m_done[k] = 1'b0;
    end else if (!m_busy[k]) begin
      if (start_d) begin
        m_map[k]   = '0;
        m_count[k] = 0;
        m_err[k]   = 1'b0;
        m_tries[k] = 0;
        m_safe[k]  = int'(safe_d);
        m_busy[k]  = 1'b1;
      end
    end else begin
      cand = int'(rand_d) % 128;
      m_tries[k]++;
      if (cand < CELLS && cand != m_safe[k] && m_map[k][cand] == 1'b0) begin
        m_map[k][cand] = 1'b1;
        m_count[k]++;
      end
      if (m_count[k] == NUM_MINES) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b1;
        m_err[k]  = 1'b0;
      end else if (m_tries[k] == m_max[k]) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b1;
        m_err[k]  = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 1'b0; m_done[k] = 1'b0; m_err[k] = 1'b0;
        m_count[k] = 0; m_tries[k] = 0; m_safe[k] = 0; m_map[k] = '0;
      end
    end else begin
      modelStep(0);
      modelStep(1);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("a_busy",  96'(bus_a.busy),       96'(m_busy[0]));
      checkOutput("a_done",  96'(bus_a.done),       96'(m_done[0]));
      checkOutput("a_err",   96'(bus_a.err),        96'(m_err[0]));
      checkOutput("a_count", 96'(bus_a.mine_count), 96'(m_count[0]));
      checkOutput("a_map",   96'(bus_a.mine_map),   96'(m_map[0]));
      checkOutput("b_busy",  96'(bus_b.busy),       96'(m_busy[1]));
      checkOutput("b_done",  96'(bus_b.done),       96'(m_done[1]));
      checkOutput("b_err",   96'(bus_b.err),        96'(m_err[1]));
      checkOutput("b_count", 96'(bus_b.mine_count), 96'(m_count[1]));
      checkOutput("b_map",   96'(bus_b.mine_map),   96'(m_map[1]));
    end
  end

  int samp[$];
  int cells[$];

  function automatic logic [CELLS-1:0] mapOf(input int c[$]);
    logic [CELLS-1:0] m = '0;
    foreach (c[i]) m[c[i]] = 1'b1;
    return m;
  endfunction

  task automatic applyStimulus(input logic s, input logic [6:0] sc, input logic [7:0] r);
    @(posedge clk);
    #1;
    start_d = s;
    safe_d  = sc;
    rand_d  = r;
  endtask

  // Issues a start, feeds samp one per cycle (then rejected filler) and counts
  // cycles after the start edge until the watched instance pulses done.
  task automatic runPlacement(input logic [6:0] sc, input bit watch_b, input int bound, output int cyc);
    logic got = 1'b0;
    applyStimulus(1'b1, sc, 8'd127);
    cyc = 0;
    while (!got && cyc < bound) begin
      cyc++;
      applyStimulus(1'b0, sc ^ 7'h55, (cyc <= samp.size()) ? 8'(samp[cyc-1]) : 8'd127);
      @(negedge clk);
      got = watch_b ? bus_b.done : bus_a.done;
    end
    checkOutput("done_seen", 96'(got), 96'd1);
  endtask

  task automatic checkIdleCleared(input string tag);
    checkOutput({tag, "_a_busy"},  96'(bus_a.busy),       96'd0);
    checkOutput({tag, "_a_done"},  96'(bus_a.done),       96'd0);
    checkOutput({tag, "_a_err"},   96'(bus_a.err),        96'd0);
    checkOutput({tag, "_a_count"}, 96'(bus_a.mine_count), 96'd0);
    checkOutput({tag, "_a_map"},   96'(bus_a.mine_map),   96'd0);
    checkOutput({tag, "_b_map"},   96'(bus_b.mine_map),   96'd0);
  endtask

  initial begin
    int cyc;

    // Asynchronous reset, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1 checkIdleCleared("reset");
    checking = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic placement: ten clean accepts.
    samp = '{10, 20, 30, 40, 50, 60, 70, 80, 1, 2};
    runPlacement(7'd0, 1'b0, 40, cyc);
    cells = '{1, 2, 10, 20, 30, 40, 50, 60, 70, 80};
    checkOutput("basic_latency", 96'(cyc), 96'd11);
    checkOutput("basic_count", 96'(bus_a.mine_count), 96'd10);
    checkOutput("basic_map", 96'(bus_a.mine_map), 96'(mapOf(cells)));
    checkOutput("basic_err", 96'(bus_a.err), 96'd0);
    checkOutput("basic_b_err", 96'(bus_b.err), 96'd1);
    checkOutput("basic_b_count", 96'(bus_b.mine_count), 96'd8);

    // Rejection: duplicate, safe cell and out-of-range samples; 200 folds to cell 72.
    samp = '{10, 10, 0, 90, 200, 20, 30, 40, 50, 60, 70, 80, 1};
    runPlacement(7'd0, 1'b0, 40, cyc);
    cells = '{1, 10, 20, 30, 40, 50, 60, 70, 72, 80};
    checkOutput("reject_latency", 96'(cyc), 96'd14);
    checkOutput("reject_map", 96'(bus_a.mine_map), 96'(mapOf(cells)));
    checkOutput("reject_count", 96'(bus_a.mine_count), 96'd10);

    // Re-arm with the safe cell on a previously mined cell.
    checkOutput("rearm_pre_bit40", 96'(bus_a.mine_map[40]), 96'd1);
    samp = '{40, 3, 40, 4, 5, 6, 7, 8, 9, 11, 12, 13};
    runPlacement(7'd40, 1'b0, 40, cyc);
    cells = '{3, 4, 5, 6, 7, 8, 9, 11, 12, 13};
    checkOutput("rearm_latency", 96'(cyc), 96'd13);
    checkOutput("rearm_bit40", 96'(bus_a.mine_map[40]), 96'd0);
    checkOutput("rearm_map", 96'(bus_a.mine_map), 96'(mapOf(cells)));
    checkOutput("rearm_err", 96'(bus_a.err), 96'd0);

    // Abort on the 8-try instance with a stuck random value.
    samp = '{};
    for (int i = 0; i < 20; i++) samp.push_back(5);
    runPlacement(7'd0, 1'b1, 40, cyc);
    checkOutput("abort_latency", 96'(cyc), 96'd9);
    checkOutput("abort_err", 96'(bus_b.err), 96'd1);
    checkOutput("abort_count", 96'(bus_b.mine_count), 96'd1);
    checkOutput("abort_map", 96'(bus_b.mine_map), 96'(82'd1 << 5));
    checkOutput("abort_a_busy", 96'(bus_a.busy), 96'd1);

    // A start while busy is ignored; the running placement keeps counting up.
    applyStimulus(1'b1, 7'd0, 8'd127);
    applyStimulus(1'b0, 7'd0, 8'd60);
    applyStimulus(1'b0, 7'd0, 8'd61);
    applyStimulus(1'b0, 7'd0, 8'd62);
    applyStimulus(1'b0, 7'd0, 8'd127);
    @(negedge clk);
    checkOutput("ignored_start_count", 96'(bus_a.mine_count), 96'd4);
    checkOutput("ignored_start_busy", 96'(bus_a.busy), 96'd1);

    // Reset in the middle of DRAW clears everything without a done pulse.
    #2 rst_n = 1'b0;
    #1 checkIdleCleared("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    samp = '{10, 20, 30, 40, 50, 60, 70, 80, 1, 2};
    runPlacement(7'd0, 1'b0, 40, cyc);
    cells = '{1, 2, 10, 20, 30, 40, 50, 60, 70, 80};
    checkOutput("after_reset_latency", 96'(cyc), 96'd11);
    checkOutput("after_reset_map", 96'(bus_a.mine_map), 96'(mapOf(cells)));
    checkOutput("after_reset_err", 96'(bus_a.err), 96'd0);

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
